// File: rtl/gpu_pkg.sv
// Shared GPU constants: data cache geometry and small sizing helpers
// used by the shared-resource arbiters.
package gpu_pkg;

    localparam int DATA_CACHE_WIDTH      = 16;
    localparam int DATA_CACHE_DEPTH      = 4096;
    localparam int DATA_CACHE_ADDR_WIDTH = $clog2(DATA_CACHE_DEPTH);

    // Width of an index into n requesters, never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// winner and the first asserted request is granted.
module rr_arbiter
    import gpu_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_in,
    input  logic [PTR_W-1:0]   last_in,
    output logic [NUM_REQ-1:0] grant_out,
    output logic [PTR_W-1:0]   grant_id_out,
    output logic               grant_valid_out
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the search so no latch is inferred.
        grant_out       = '0;
        grant_id_out    = '0;
        grant_valid_out = 1'b0;
        idx             = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_in) + k) % NUM_REQ;
            if (!grant_valid_out && req_in[idx]) begin
                grant_valid_out = 1'b1;
                grant_out[idx]  = 1'b1;
                grant_id_out    = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/data_cache_arbiter.sv
// Shares the single-port data cache BRAM among NUM_REQ requesters through a
// registered issue stage, returning read data in order via a tag pipeline.
module data_cache_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = DATA_CACHE_WIDTH,
    parameter int ADDR_WIDTH   = DATA_CACHE_ADDR_WIDTH,
    parameter int READ_LATENCY = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    input  logic [NUM_REQ-1:0]            req_we_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
    output logic [NUM_REQ-1:0]            resp_valid_out,
    output logic [DATA_WIDTH-1:0]         resp_data_out,
    output logic                          cache_en_out,
    output logic                          cache_we_out,
    output logic [ADDR_WIDTH-1:0]         cache_addr_out,
    output logic [DATA_WIDTH-1:0]         cache_din_out,
    input  logic [DATA_WIDTH-1:0]         cache_dout_in,
    output logic                          busy_out
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      grant_id;
    logic                  grant_valid;
    logic                  accept;

    logic                  en_q, en_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [NUM_REQ-1:0]    owner_q, owner_d;
    logic [PTR_W-1:0]      last_q, last_d;
    logic [NUM_REQ-1:0]    tag_q [READ_LATENCY+1];
    logic [NUM_REQ-1:0]    tag_d [READ_LATENCY+1];
    logic [NUM_REQ-1:0]    tag_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_in          (req_valid_in),
        .last_in         (last_q),
        .grant_out       (grant),
        .grant_id_out    (grant_id),
        .grant_valid_out (grant_valid)
    );

    // Nothing may be granted while reset holds the issue stage clear.
    assign req_ready_out = rst_in ? grant : '0;
    assign accept        = rst_in & grant_valid;

    always_comb begin
        en_d    = accept;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        owner_d = '0;
        last_d  = last_q;
        if (accept) begin
            we_d    = req_we_in[grant_id];
            addr_d  = req_addr_in[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
            din_d   = req_data_in[grant_id*DATA_WIDTH +: DATA_WIDTH];
            owner_d = grant;
            last_d  = grant_id;
        end

        // A tag enters when the BRAM samples the read, so the tail lines up with dout.
        tag_d[0] = (en_q && !we_q) ? owner_q : '0;
        for (int s = 1; s <= READ_LATENCY; s++) begin
            tag_d[s] = tag_q[s-1];
        end

        tag_any = '0;
        for (int s = 0; s <= READ_LATENCY; s++) begin
            tag_any = tag_any | tag_q[s];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            owner_q <= '0;
            last_q  <= PTR_W'(NUM_REQ - 1);
            // NOTE: the tag pipe is reset because it is control state; the BRAM contents never are.
            for (int s = 0; s <= READ_LATENCY; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            for (int s = 0; s <= READ_LATENCY; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    assign cache_en_out   = en_q;
    assign cache_we_out   = we_q;
    assign cache_addr_out = addr_q;
    assign cache_din_out  = din_q;
    assign resp_valid_out = tag_q[READ_LATENCY];
    assign resp_data_out  = cache_dout_in;
    assign busy_out       = en_q | (|tag_any);

endmodule

// File: tb/tb_data_cache_arbiter.sv
// Scoreboard bench for data_cache_arbiter: directed stimulus pushes expected
// grants and read responses; negedge monitors pop and compare.
module tb_data_cache_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 12;
    localparam int RL = 2;

    typedef struct packed {
        logic [N-1:0]  id;
        logic [DW-1:0] data;
        logic [31:0]   cyc;
    } resp_t;

    logic            clk_in      = 1'b0;
    logic            rst_in      = 1'b0;
    logic [N-1:0]    req_valid_in = '0;
    logic [N-1:0]    req_we_in    = '0;
    logic [N*AW-1:0] req_addr_in  = '0;
    logic [N*DW-1:0] req_data_in  = '0;
    logic [N-1:0]    req_ready_out;
    logic [N-1:0]    resp_valid_out;
    logic [DW-1:0]   resp_data_out;
    logic            cache_en_out;
    logic            cache_we_out;
    logic [AW-1:0]   cache_addr_out;
    logic [DW-1:0]   cache_din_out;
    logic [DW-1:0]   cache_dout_in;
    logic            busy_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    resp_t         exp_resp_q[$];
    logic [N-1:0]  exp_grant_q[$];
    logic [DW-1:0] ref_mem [int];
    resp_t         mon_e;

    data_cache_arbiter #(
        .NUM_REQ      (N),
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .READ_LATENCY (RL)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .req_we_in      (req_we_in),
        .req_addr_in    (req_addr_in),
        .req_data_in    (req_data_in),
        .resp_valid_out (resp_valid_out),
        .resp_data_out  (resp_data_out),
        .cache_en_out   (cache_en_out),
        .cache_we_out   (cache_we_out),
        .cache_addr_out (cache_addr_out),
        .cache_din_out  (cache_din_out),
        .cache_dout_in  (cache_dout_in),
        .busy_out       (busy_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // BRAM model: read-first, address sampled on one edge, dout valid RL edges later.
    logic [DW-1:0] bram [4096];
    logic [DW-1:0] rd_pipe [RL];
    logic [DW-1:0] bram_dout;
    logic          load_en   = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;

    always @(posedge clk_in) begin
        if (load_en) bram[load_addr] <= load_data;
        else if (cache_en_out && cache_we_out) bram[cache_addr_out] <= cache_din_out;
        if (cache_en_out) rd_pipe[0] <= bram[cache_addr_out];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
        bram_dout <= rd_pipe[RL-1];
    end
    assign cache_dout_in = bram_dout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Grant monitor.
    always @(negedge clk_in) begin
        if (rst_in && req_ready_out != '0) begin
            if (exp_grant_q.size() == 0) check("grant_unexpected", 32'(req_ready_out), 32'd0);
            else check("grant_order", 32'(req_ready_out), 32'(exp_grant_q.pop_front()));
        end
    end

    // Response monitor.
    always @(negedge clk_in) begin
        if (resp_valid_out != '0) begin
            if (exp_resp_q.size() == 0) begin
                check("resp_unexpected", 32'(resp_valid_out), 32'd0);
            end else begin
                mon_e = exp_resp_q.pop_front();
                check("resp_id", 32'(resp_valid_out), 32'(mon_e.id));
                check("resp_data", 32'(resp_data_out), 32'(mon_e.data));
                check("resp_latency", 32'(cyc), mon_e.cyc + 32'd3);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        ref_mem[int'(a)] = d;
        @(posedge clk_in); #1;
        load_en = 1'b0;
    endtask

    task automatic set_req(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_we_in[i]              = we;
        req_addr_in[i*AW +: AW]   = a;
        req_data_in[i*DW +: DW]   = d;
        req_valid_in[i]           = 1'b1;
    endtask

    // Records accepted requests: writes update the reference, reads queue a response.
    task automatic record(input logic [N-1:0] hs);
        logic [AW-1:0] a;
        resp_t         e;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                a = req_addr_in[i*AW +: AW];
                if (req_we_in[i]) begin
                    ref_mem[int'(a)] = req_data_in[i*DW +: DW];
                end else begin
                    e.id    = '0;
                    e.id[i] = 1'b1;
                    e.data  = ref_mem[int'(a)];
                    e.cyc   = 32'(cyc + 1);
                    exp_resp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic step(input bit clear);
        logic [N-1:0] hs;
        @(negedge clk_in);
        hs = req_valid_in & req_ready_out;
        record(hs);
        @(posedge clk_in); #1;
        if (clear) req_valid_in = req_valid_in & ~hs;
    endtask

    task automatic drive(input int budget);
        int c;
        c = 0;
        while (req_valid_in != '0 && c < budget) begin
            step(1'b1);
            c++;
        end
        check("grant_timeout", 32'(req_valid_in), 32'd0);
        req_valid_in = '0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((exp_resp_q.size() != 0 || busy_out) && c < 20) begin
            @(negedge clk_in);
            c++;
        end
        check("drain_resp_q", 32'(exp_resp_q.size()), 32'd0);
        check("drain_grant_q", 32'(exp_grant_q.size()), 32'd0);
        check("drain_busy", 32'(busy_out), 32'd0);
        @(posedge clk_in); #1;
    endtask

    task automatic do_reset();
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        exp_resp_q.delete();
        req_valid_in = '1;
        @(negedge clk_in);
        check("rst_ready", 32'(req_ready_out), 32'd0);
        check("rst_resp_valid", 32'(resp_valid_out), 32'd0);
        check("rst_cache_en", 32'(cache_en_out), 32'd0);
        check("rst_cache_we", 32'(cache_we_out), 32'd0);
        check("rst_cache_addr", 32'(cache_addr_out), 32'd0);
        check("rst_cache_din", 32'(cache_din_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        req_valid_in = '0;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
    endtask

    initial begin
        preload(12'h005, 16'h1234);
        preload(12'h000, 16'h00A0);
        preload(12'h001, 16'h00A1);
        preload(12'h002, 16'h00A2);
        preload(12'h003, 16'h00A3);
        preload(12'h010, 16'h1111);
        preload(12'h030, 16'h3333);
        do_reset();

        // Single read from requester 2.
        exp_grant_q.push_back(4'b0100);
        set_req(2, 1'b0, 12'h005, 16'h0000);
        drive(8);
        drain();

        // Write then read the same address from requester 0.
        exp_grant_q.push_back(4'b0001);
        exp_grant_q.push_back(4'b0001);
        set_req(0, 1'b1, 12'h0FF, 16'hBEEF);
        step(1'b0);
        check("wr_cache_en", 32'(cache_en_out), 32'd1);
        check("wr_cache_we", 32'(cache_we_out), 32'd1);
        check("wr_cache_addr", 32'(cache_addr_out), 32'h0FF);
        check("wr_cache_din", 32'(cache_din_out), 32'hBEEF);
        req_we_in[0] = 1'b0;
        drive(8);
        drain();

        // Full contention: grants 0,1,2,3 and back-to-back strobes.
        do_reset();
        for (int i = 0; i < N; i++) begin
            exp_grant_q.push_back(4'(1 << i));
            set_req(i, 1'b0, 12'(i), 16'h0000);
        end
        drive(10);
        drain();

        // Fairness: requesters 1 and 3 held valid alternate.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_grant_q.push_back(4'b0010);
            exp_grant_q.push_back(4'b1000);
        end
        set_req(1, 1'b0, 12'h010, 16'h0000);
        set_req(3, 1'b0, 12'h030, 16'h0000);
        repeat (8) step(1'b0);
        req_valid_in = '0;
        drain();

        // Reset one cycle after the third accept drops all in-flight reads.
        do_reset();
        exp_grant_q.push_back(4'b0001);
        exp_grant_q.push_back(4'b0010);
        exp_grant_q.push_back(4'b0100);
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 12'(i), 16'h0000);
        drive(10);
        do_reset();
        repeat (5) begin
            @(negedge clk_in);
            check("post_rst_busy", 32'(busy_out), 32'd0);
            check("post_rst_resp", 32'(resp_valid_out), 32'd0);
        end
        @(posedge clk_in); #1;
        exp_grant_q.push_back(4'b0001);
        exp_grant_q.push_back(4'b0100);
        set_req(0, 1'b0, 12'h003, 16'h0000);
        set_req(2, 1'b0, 12'h001, 16'h0000);
        drive(6);
        drain();

        // Idle: nothing issued, nothing returned.
        repeat (10) begin
            @(negedge clk_in);
            check("idle_cache_en", 32'(cache_en_out), 32'd0);
            check("idle_busy", 32'(busy_out), 32'd0);
            check("idle_resp", 32'(resp_valid_out), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_cache_arbiter.md
# data_cache_arbiter

Shares the single-port data cache BRAM (16-bit words, 4096 deep, 2-cycle registered read) among up to NUM_REQ requesters: the controller and the compute cores. Each cycle it grants at most one request using round-robin priority and drives the BRAM port from a registered issue stage. It tracks in-flight reads in a tag pipeline so read data returns in order to the requester that issued it. It sits between the controller/core load-store paths and the data cache RAM instance.

## Interface
- NUM_REQ, 4, number of requesters (2..8); requester 0 is the controller
- DATA_WIDTH, 16, bits per cache word
- ADDR_WIDTH, 12, cache address bits (log2 of 4096)
- READ_LATENCY, 2, BRAM clock edges from address sample to valid dout

Ports:
- clk_in  input  1  the only clock
- rst_in  input  1  reset, asynchronous, active-low
- req_valid_in  input  NUM_REQ  per-requester request valid
- req_ready_out  output  NUM_REQ  per-requester grant, at most one bit set
- req_we_in  input  NUM_REQ  1 = write, 0 = read
- req_addr_in  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data_in  input  NUM_REQ*DATA_WIDTH  packed write data, same packing
- resp_valid_out  output  NUM_REQ  one-hot read-data strobe
- resp_data_out  output  DATA_WIDTH  read data, shared by all requesters
- cache_en_out, cache_we_out  output  1  BRAM port enable and write enable
- cache_addr_out  output  ADDR_WIDTH  BRAM address
- cache_din_out  output  DATA_WIDTH  BRAM write data
- cache_dout_in  input  DATA_WIDTH  BRAM read data
- busy_out  output  1  any read in flight or issue stage occupied

## Operation
- Grant is combinational from req_valid_in and the round-robin pointer `last`. Search starts at `last+1` mod NUM_REQ. The first valid requester gets req_ready_out.
- A handshake completes on an edge where valid && ready. On that edge:
  - the issue register captures en=1, the requester's we, addr and data;
  - `last` is set to the winner.
- With no handshake, the issue register loads en=0, we=0. addr and din hold their previous values.
- Reads push tag {valid, one-hot id} into a READ_LATENCY+1 deep shift register. Writes and idle cycles push valid=0.
- At the tail of the shift register, resp_valid_out equals the tail one-hot. resp_data_out is cache_dout_in passed through unregistered.
- Responses return in issue order and cannot be refused. Requesters must sink them.
- The port is a single read-first port. A write followed by a read to the same address returns the new data.
- Requesters hold valid, we, addr and data stable until ready. A valid request is never starved: at most NUM_REQ-1 other grants occur before it is granted.
- Reset (asynchronous, mid-operation included):
  - clears the issue register and tag pipe; in-flight reads are dropped with no strobe;
  - sets `last` = NUM_REQ-1, so requester 0 has first priority.

## Timing
- Reset values: req_ready_out=0, resp_valid_out=0, cache_en_out=0, cache_we_out=0, cache_addr_out=0, cache_din_out=0, busy_out=0.
- While rst_in is low, req_ready_out is forced to 0.
- Accept edge T: BRAM inputs are visible in cycle T+1 and sampled at edge T+1. Read data and resp_valid_out are valid in the cycle after edge T+1+READ_LATENCY, i.e. READ_LATENCY+1 edges after accept.
- Throughput: one request per cycle sustained. Back-to-back reads from different requesters give back-to-back strobes.
- Single valid requester: it is granted every cycle it is valid.
- Simultaneous valids: exactly one grant per cycle, in round-robin order.

## Structure
- Shared package gpu_pkg holds DATA_CACHE_WIDTH=16, DATA_CACHE_DEPTH=4096, and the derived cache address width.
- Sub-module rr_arbiter: combinational round-robin grant from (request vector, last pointer). It is parameterised by NUM_REQ and reused by later shared-resource blocks.
- The issue register, tag pipe and pointer register live in data_cache_arbiter.

## Test plan
- Single read: reset, then requester 2 reads addr 0x005 holding 0x1234 → ready[2] for one cycle; resp_valid_out=4'b0100 with resp_data_out=0x1234 exactly 3 edges after accept; no other strobes.
- Write then read: requester 0 writes 0xBEEF to 0x0FF, then reads 0x0FF on the next cycle → two consecutive grants; read returns 0xBEEF.
- Full contention: all four requesters hold reads (addrs 0..3, contents 0xA0..0xA3) → grants in order 0,1,2,3; strobes 0001, 0010, 0100, 1000 on consecutive cycles with data 0xA0..0xA3.
- Fairness: requesters 1 and 3 continuously valid → grants alternate 1,3,1,3; requester 1 never waits more than 1 cycle.
- Reset mid-flight: issue 3 reads, assert rst_in low one cycle after the third accept → no resp_valid_out pulses afterward, busy_out=0; the next request from requester 0 is granted first.
- Idle: no valids for 10 cycles → cache_en_out=0, busy_out=0, resp_valid_out=0 throughout.
